// File: rtl/vga_scanout.sv
// vga_scanout: VGA read side of the 1-bit capture frame buffer.
// Doubles each buffer row onto two lines inside a centred window.
module vga_scanout #(
    parameter int         H_ACTIVE = 800,
    parameter int         H_FP     = 40,
    parameter int         H_SYNC   = 128,
    parameter int         H_BP     = 88,
    parameter int         V_ACTIVE = 600,
    parameter int         V_FP     = 1,
    parameter int         V_SYNC   = 4,
    parameter int         V_BP     = 23,
    parameter logic       SYNC_POL = 1'b1,
    parameter int         FB_W     = 800,
    parameter int         FB_H     = 240,
    parameter int         V_OFFSET = 60,
    parameter int         RD_LAT   = 2,
    parameter logic [2:0] FG_COLOR = 3'b010
) (
    input  logic        pixclk,
    input  logic        rst_n,
    output logic [17:0] raddr,
    output logic        rden,
    input  logic        rdata,
    input  logic        clear_busy,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_r,
    output logic        vga_g,
    output logic        vga_b,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = 11;
    localparam int VW = 10;
    localparam int AW = 18;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] FB_WH  = HW'(FB_W);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] W_BEG  = VW'(V_OFFSET);
    localparam logic [VW-1:0] W_END  = VW'(V_OFFSET + 2 * FB_H);
    localparam logic [AW-1:0] ROW_STEP = AW'(FB_W);

    typedef struct packed {
        logic fs;
        logic hs;
        logic vs;
        logic act;
        logic win;
    } flags_t;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [AW-1:0] line_base;
    logic          h_wrap;
    logic          v_wrap;
    logic          win_line;
    logic          win_odd;
    flags_t        f0;
    flags_t        dly [RD_LAT];
    flags_t        dq;
    logic [1:0]    clr_sync;
    logic          blank_frame;
    logic          pix_on;

    assign dq     = dly[RD_LAT-1];
    assign pix_on = dq.act & dq.win & rdata & ~blank_frame;

    // Stage-0 decode of raster position into sync/active/window flags.
    always_comb begin
        f0       = '0;
        h_wrap   = (hcnt == H_LAST);
        v_wrap   = (vcnt == V_LAST);
        win_line = (vcnt >= W_BEG) && (vcnt < W_END);
        // Parity of (vcnt - V_OFFSET) without a subtractor.
        win_odd  = vcnt[0] ^ W_BEG[0];
        f0.fs    = (hcnt == '0) && (vcnt == '0);
        f0.hs    = (hcnt >= HS_BEG) && (hcnt < HS_END);
        f0.vs    = (vcnt >= VS_BEG) && (vcnt < VS_END);
        f0.act   = (hcnt < H_ACT) && (vcnt < V_ACT);
        f0.win   = win_line && (hcnt < FB_WH);
    end

    // Raster counters: hcnt wraps per line, vcnt per frame.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_wrap) begin
            hcnt <= '0;
            vcnt <= v_wrap ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // Row base address; advances after every second window line.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n)
            line_base <= '0;
        else if (vcnt == '0)
            line_base <= '0;
        else if (h_wrap && win_line && win_odd)
            line_base <= line_base + ROW_STEP;
    end

    // Registered read request; first clock of the read latency.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            rden  <= 1'b0;
            raddr <= '0;
        end else begin
            rden  <= f0.win;
            raddr <= f0.win ? line_base + AW'(hcnt) : '0;
        end
    end

    // Flag delay line so timing lines up with returning rdata.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++)
                dly[i] <= '0;
        end else begin
            dly[0] <= f0;
            for (int i = 1; i < RD_LAT; i++)
                dly[i] <= dly[i-1];
        end
    end

    // clear_busy synchroniser; blanking latched only at frame start.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            clr_sync    <= 2'b00;
            blank_frame <= 1'b1;
        end else begin
            clr_sync <= {clr_sync[0], clear_busy};
            if (f0.fs)
                blank_frame <= clr_sync[1];
        end
    end

    // Output pin register.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hsync             <= ~SYNC_POL;
            vga_vsync             <= ~SYNC_POL;
            {vga_r, vga_g, vga_b} <= 3'b000;
            frame_start           <= 1'b0;
        end else begin
            vga_hsync             <= dq.hs ? SYNC_POL : ~SYNC_POL;
            vga_vsync             <= dq.vs ? SYNC_POL : ~SYNC_POL;
            {vga_r, vga_g, vga_b} <= pix_on ? FG_COLOR : 3'b000;
            frame_start           <= dq.fs;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of scanout timing, addressing,
// blanking and reset on a scaled raster (25x17, 8x4 buffer).
module tb_vga_scanout;
    localparam int HT = 25;
    localparam int FT = 425;

    logic        pixclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_busy = 1'b0;
    logic [17:0] raddr, raddr3;
    logic        rden, rden3;
    logic        rdata = 1'b0;
    logic        rdata3 = 1'b0;
    logic        rd3a = 1'b0;
    logic        hs, vs, r, g, b, fs;
    logic        hs3, vs3, r3, g3, b3, fs3;
    logic [2:0]  rgb, rgb3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nz = 0;

    assign rgb  = {r, g, b};
    assign rgb3 = {r3, g3, b3};

    always #5 pixclk = ~pixclk;

    // RAM models: only address 0 holds a set bit, rden not honoured.
    always @(posedge pixclk) rdata <= (raddr == 18'd0);
    always @(posedge pixclk) begin
        rd3a   <= (raddr3 == 18'd0);
        rdata3 <= rd3a;
    end

    vga_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .FB_W(8), .FB_H(4), .V_OFFSET(2),
        .RD_LAT(2), .FG_COLOR(3'b010)
    ) u_dut (
        .pixclk(pixclk), .rst_n(rst_n), .raddr(raddr), .rden(rden),
        .rdata(rdata), .clear_busy(clear_busy), .vga_hsync(hs),
        .vga_vsync(vs), .vga_r(r), .vga_g(g), .vga_b(b),
        .frame_start(fs)
    );

    vga_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .FB_W(8), .FB_H(4), .V_OFFSET(2),
        .RD_LAT(3), .FG_COLOR(3'b010)
    ) u_dut3 (
        .pixclk(pixclk), .rst_n(rst_n), .raddr(raddr3), .rden(rden3),
        .rdata(rdata3), .clear_busy(clear_busy), .vga_hsync(hs3),
        .vga_vsync(vs3), .vga_r(r3), .vga_g(g3), .vga_b(b3),
        .frame_start(fs3)
    );

    task automatic step();
        @(posedge pixclk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic run_count(input int t);
        while (cyc < t) begin
            step();
            if (rgb !== 3'b000) nz++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge pixclk);
        @(negedge pixclk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_busy = 1'b0;
        repeat (3) @(posedge pixclk);
        #1;
        checks++;
        if (hs !== 1'b0) begin
            errors++; $display("FAIL rst_hsync got %b want 0", hs);
        end
        checks++;
        if (vs !== 1'b0) begin
            errors++; $display("FAIL rst_vsync got %b want 0", vs);
        end
        checks++;
        if (rgb !== 3'b000) begin
            errors++; $display("FAIL rst_rgb got %b want 000", rgb);
        end
        checks++;
        if (fs !== 1'b0) begin
            errors++; $display("FAIL rst_fs got %b want 0", fs);
        end
        checks++;
        if (rden !== 1'b0 || raddr !== 18'd0) begin
            errors++;
            $display("FAIL rst_rd got %b/%0d want 0/0", rden, raddr);
        end
        @(negedge pixclk);
        rst_n = 1'b1;
        cyc = 0;
        goto(2);
        checks++;
        if (fs !== 1'b0) begin
            errors++; $display("FAIL fs_early got %b want 0", fs);
        end
        goto(3);
        checks++;
        if (fs !== 1'b1) begin
            errors++; $display("FAIL fs_first got %b want 1", fs);
        end
        goto(4);
        checks++;
        if (fs !== 1'b0) begin
            errors++; $display("FAIL fs_width got %b want 0", fs);
        end
    endtask

    task automatic test_timing();
        int hr1 = -1, hr2 = -1, hf1 = -1;
        int vr1 = -1, vr2 = -1, vf1 = -1;
        int f1 = -1, f2 = -1;
        int p1 = -1, p2 = -1, pc = 0;
        logic [2:0] pv1 = 3'b000;
        logic hp = hs;
        logic vp = vs;
        while (cyc < 900) begin
            step();
            if (hs && !hp) begin
                if (hr1 < 0) hr1 = cyc;
                else if (hr2 < 0) hr2 = cyc;
            end
            if (!hs && hp && hf1 < 0) hf1 = cyc;
            if (vs && !vp) begin
                if (vr1 < 0) vr1 = cyc;
                else if (vr2 < 0) vr2 = cyc;
            end
            if (!vs && vp && vf1 < 0) vf1 = cyc;
            if (fs) begin
                if (f1 < 0) f1 = cyc;
                else if (f2 < 0) f2 = cyc;
            end
            if (rgb !== 3'b000) begin
                pc++;
                if (p1 < 0) begin
                    p1 = cyc; pv1 = rgb;
                end else if (p2 < 0) p2 = cyc;
            end
            hp = hs;
            vp = vs;
        end
        checks++;
        if (hr1 != 21 || hf1 != 25) begin
            errors++;
            $display("FAIL hsync_pulse got %0d..%0d want 21..25", hr1, hf1);
        end
        checks++;
        if (hr2 - hr1 != HT) begin
            errors++;
            $display("FAIL hsync_period got %0d want %0d", hr2 - hr1, HT);
        end
        checks++;
        if (vr1 != 328 || vf1 != 378) begin
            errors++;
            $display("FAIL vsync_pulse got %0d..%0d want 328..378", vr1, vf1);
        end
        checks++;
        if (vr2 - vr1 != FT) begin
            errors++;
            $display("FAIL vsync_period got %0d want %0d", vr2 - vr1, FT);
        end
        checks++;
        if (f1 != 428 || f2 != 853) begin
            errors++;
            $display("FAIL fs_period got %0d,%0d want 428,853", f1, f2);
        end
        checks++;
        if (p1 != 53 || p2 != 78 || pv1 !== 3'b010) begin
            errors++;
            $display("FAIL pix_pos got %0d,%0d val %b want 53,78 val 010",
                     p1, p2, pv1);
        end
        checks++;
        if (pc != 4) begin
            errors++; $display("FAIL pix_count got %0d want 4", pc);
        end
    endtask

    task automatic test_addr();
        int pf [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        int pv [13] = '{0, 1, 2, 3, 4, 5, 6, 9, 9, 10, 16, 2, 2};
        int ph [13] = '{0, 5, 0, 7, 0, 3, 16, 7, 8, 0, 24, 0, 7};
        int ee [13] = '{0, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1};
        int ea [13] = '{0, 0, 0, 7, 8, 11, 0, 31, 0, 0, 0, 0, 7};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            goto(pf[i] * FT + pv[i] * HT + ph[i] + 1);
            checks++;
            if (rden !== ee[i][0] || raddr !== 18'(ea[i])) begin
                errors++;
                $display("FAIL addr_v%0d_h%0d got %b/%0d want %0d/%0d",
                         pv[i], ph[i], rden, raddr, ee[i], ea[i]);
            end
        end
    endtask

    task automatic test_clear_busy();
        do_reset();
        goto(440);
        clear_busy = 1'b1;
        goto(478);
        checks++;
        if (rgb !== 3'b010) begin
            errors++; $display("FAIL clr_keep_a got %b want 010", rgb);
        end
        goto(503);
        checks++;
        if (rgb !== 3'b010) begin
            errors++; $display("FAIL clr_keep_b got %b want 010", rgb);
        end
        nz = 0;
        run_count(853);
        checks++;
        if (fs !== 1'b1) begin
            errors++; $display("FAIL clr_fs got %b want 1", fs);
        end
        run_count(871);
        checks++;
        if (hs !== 1'b1) begin
            errors++; $display("FAIL clr_hsync got %b want 1", hs);
        end
        run_count(1000);
        clear_busy = 1'b0;
        run_count(1178);
        checks++;
        if (vs !== 1'b1) begin
            errors++; $display("FAIL clr_vsync got %b want 1", vs);
        end
        run_count(1300);
        checks++;
        if (nz != 0) begin
            errors++; $display("FAIL clr_black got %0d lit want 0", nz);
        end
        goto(1328);
        checks++;
        if (rgb !== 3'b010) begin
            errors++; $display("FAIL clr_resume_a got %b want 010", rgb);
        end
        goto(1353);
        checks++;
        if (rgb !== 3'b010) begin
            errors++; $display("FAIL clr_resume_b got %b want 010", rgb);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        goto(78);
        checks++;
        if (rgb !== 3'b010 || rden !== 1'b1 || raddr !== 18'd2) begin
            errors++;
            $display("FAIL mid_pre got %b %b %0d want 010 1 2",
                     rgb, rden, raddr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rgb !== 3'b000 || rden !== 1'b0 || raddr !== 18'd0) begin
            errors++;
            $display("FAIL mid_async got %b %b %0d want 000 0 0",
                     rgb, rden, raddr);
        end
        @(negedge pixclk);
        rst_n = 1'b1;
        cyc = 0;
        goto(20);
        checks++;
        if (hs !== 1'b0) begin
            errors++; $display("FAIL mid_hs_pre got %b want 0", hs);
        end
        goto(21);
        checks++;
        if (hs !== 1'b1) begin
            errors++; $display("FAIL mid_hs_rise got %b want 1", hs);
        end
    endtask

    task automatic test_rdlat3();
        do_reset();
        goto(3);
        checks++;
        if (fs3 !== 1'b0) begin
            errors++; $display("FAIL l3_fs_pre got %b want 0", fs3);
        end
        goto(4);
        checks++;
        if (fs3 !== 1'b1) begin
            errors++; $display("FAIL l3_fs got %b want 1", fs3);
        end
        goto(21);
        checks++;
        if (hs3 !== 1'b0) begin
            errors++; $display("FAIL l3_hs_pre got %b want 0", hs3);
        end
        goto(22);
        checks++;
        if (hs3 !== 1'b1) begin
            errors++; $display("FAIL l3_hs_rise got %b want 1", hs3);
        end
        goto(53);
        checks++;
        if (rgb3 !== 3'b000) begin
            errors++; $display("FAIL l3_pix_pre got %b want 000", rgb3);
        end
        goto(54);
        checks++;
        if (rgb3 !== 3'b010) begin
            errors++; $display("FAIL l3_pix got %b want 010", rgb3);
        end
        goto(55);
        checks++;
        if (rgb3 !== 3'b000) begin
            errors++; $display("FAIL l3_pix_post got %b want 000", rgb3);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_timing();
        test_addr();
        test_clear_busy();
        test_reset_mid();
        test_rdlat3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
